// File: rtl/ln_pkg.sv
// Shared defaults for the input quantizer/packer: sizes, reset threshold table, FSM states.
package ln_pkg;

    localparam int NUM_FEAT_DEF = 16;
    localparam int IN_W_DEF     = 8;
    localparam int Q_W_DEF      = 2;
    localparam int NUM_THR_DEF  = (1 << Q_W_DEF) - 1;

    // Entry (i,k) sits at [(i*NUM_THR_DEF + k)*IN_W_DEF +: IN_W_DEF]; every feature uses 64/128/192.
    localparam logic [NUM_FEAT_DEF*NUM_THR_DEF*IN_W_DEF-1:0] DEF_THRESH =
        {NUM_FEAT_DEF{8'd192, 8'd128, 8'd64}};

    typedef enum logic [1:0] {
        ST_FILL    = 2'd0,
        ST_DISCARD = 2'd1,
        ST_STALL   = 2'd2
    } state_t;

    function automatic logic [IN_W_DEF-1:0] def_thresh(input int i, input int k);
        return DEF_THRESH[((i % NUM_FEAT_DEF)*NUM_THR_DEF + (k % NUM_THR_DEF))*IN_W_DEF +: IN_W_DEF];
    endfunction

endpackage

// File: rtl/ln_feat_quantizer.sv
// Combinational thermometer encoder: code = number of thresholds the sample meets or exceeds.
// The count cannot exceed 2**Q_W-1, so saturation falls out of the threshold count.
module ln_feat_quantizer #(
    parameter int IN_W = 8,
    parameter int Q_W  = 2,
    localparam int NUM_THR = (1 << Q_W) - 1
) (
    input  logic [IN_W-1:0]         i_data,
    input  logic [NUM_THR*IN_W-1:0] i_thresh,
    output logic [Q_W-1:0]          o_code
);

    logic [Q_W-1:0] w_cnt;

    always_comb begin
        w_cnt = '0;
        for (int k = 0; k < NUM_THR; k++) begin
            if (i_data >= i_thresh[k*IN_W +: IN_W]) begin
                w_cnt = w_cnt + 1'b1;
            end
        end
        o_code = w_cnt;
    end

endmodule

// File: rtl/ln_input_quant_packer.sv
// Serial feature stream -> packed code vector for layer0; LN_THRESH_PROG_EN adds writable thresholds.
// Latency 1 cycle; s_ready drops only in STALL, while a completed vector waits for the output register.
module ln_input_quant_packer
    import ln_pkg::*;
#(
    parameter int NUM_FEAT = NUM_FEAT_DEF,
    parameter int IN_W     = IN_W_DEF,
    parameter int Q_W      = Q_W_DEF,
    localparam int CFG_AW  = $clog2(NUM_FEAT*((1 << Q_W) - 1))
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    s_valid,
    output logic                    s_ready,
    input  logic [IN_W-1:0]         s_data,
    input  logic                    s_last,
    output logic                    m_valid,
    input  logic                    m_ready,
    output logic [NUM_FEAT*Q_W-1:0] m_data,
    output logic                    err_len
`ifdef LN_THRESH_PROG_EN
    ,
    input  logic                    cfg_we,
    input  logic [CFG_AW-1:0]       cfg_addr,
    input  logic [IN_W-1:0]         cfg_data
`endif
);

    localparam int NUM_THR = (1 << Q_W) - 1;
    localparam int THR_W   = NUM_THR*IN_W;
    localparam int VEC_W   = NUM_FEAT*Q_W;
    localparam int IDX_W   = (NUM_FEAT > 1) ? $clog2(NUM_FEAT) : 1;

    function automatic logic [NUM_FEAT*THR_W-1:0] build_def();
        logic [NUM_FEAT*THR_W-1:0] v;
        v = '0;
        for (int i = 0; i < NUM_FEAT; i++) begin
            for (int k = 0; k < NUM_THR; k++) begin
                v[(i*NUM_THR + k)*IN_W +: IN_W] = IN_W'(def_thresh(i, k));
            end
        end
        return v;
    endfunction

    localparam logic [NUM_FEAT*THR_W-1:0] DEF_THR = build_def();

    logic [NUM_FEAT*THR_W-1:0] w_thr;

`ifdef LN_THRESH_PROG_EN
    logic [NUM_FEAT*THR_W-1:0] r_thr;

    // A write lands at the clock edge, so a beat in the same cycle still sees the old value.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_thr <= DEF_THR;
        end else if (cfg_we && (int'(cfg_addr) < NUM_FEAT*NUM_THR)) begin
            r_thr[int'(cfg_addr)*IN_W +: IN_W] <= cfg_data;
        end
    end

    assign w_thr = r_thr;
`else
    assign w_thr = DEF_THR;
`endif

    state_t           r_state;
    state_t           w_state_nxt;
    logic [IDX_W-1:0] r_idx;
    logic [VEC_W-1:0] r_acc;
    logic [VEC_W-1:0] r_hold;
    logic [VEC_W-1:0] r_m_data;
    logic             r_m_valid;
    logic             r_err;

    logic [VEC_W-1:0] w_vec;
    logic [Q_W-1:0]   w_code;
    logic             w_beat;
    logic             w_idx_last;
    logic             w_out_free;
    logic             w_load_new;
    logic             w_load_hold;
    logic             w_save_hold;
    logic             w_err;
    logic             w_idx_clr;
    logic             w_idx_inc;
    logic             w_acc_wr;

    assign s_ready    = (r_state != ST_STALL);
    assign w_beat     = s_valid && s_ready;
    assign w_idx_last = (r_idx == IDX_W'(NUM_FEAT - 1));
    assign w_out_free = !r_m_valid || m_ready;

    ln_feat_quantizer #(
        .IN_W (IN_W),
        .Q_W  (Q_W)
    ) u_quant (
        .i_data   (s_data),
        .i_thresh (w_thr[r_idx*THR_W +: THR_W]),
        .o_code   (w_code)
    );

    // Completed vector = stored codes plus the code of the beat being accepted now.
    always_comb begin
        w_vec = r_acc;
        w_vec[r_idx*Q_W +: Q_W] = w_code;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_load_new  = 1'b0;
        w_load_hold = 1'b0;
        w_save_hold = 1'b0;
        w_err       = 1'b0;
        w_idx_clr   = 1'b0;
        w_idx_inc   = 1'b0;
        w_acc_wr    = 1'b0;
        case (r_state)
            ST_FILL: begin
                if (w_beat) begin
                    if (w_idx_last) begin
                        w_idx_clr = 1'b1;
                        if (s_last) begin
                            if (w_out_free) begin
                                w_load_new = 1'b1;
                            end else begin
                                w_save_hold = 1'b1;
                                w_state_nxt = ST_STALL;
                            end
                        end else begin
                            w_err       = 1'b1;
                            w_state_nxt = ST_DISCARD;
                        end
                    end else if (s_last) begin
                        w_err     = 1'b1;
                        w_idx_clr = 1'b1;
                    end else begin
                        w_idx_inc = 1'b1;
                        w_acc_wr  = 1'b1;
                    end
                end
            end
            ST_DISCARD: begin
                if (w_beat && s_last) begin
                    w_state_nxt = ST_FILL;
                end
            end
            ST_STALL: begin
                // m_valid is always set here, so m_ready alone means the output transfers.
                if (m_ready) begin
                    w_load_hold = 1'b1;
                    w_state_nxt = ST_FILL;
                end
            end
            default: w_state_nxt = ST_FILL;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= ST_FILL;
            r_idx     <= '0;
            r_acc     <= '0;
            r_hold    <= '0;
            r_m_valid <= 1'b0;
            r_m_data  <= '0;
            r_err     <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_err   <= w_err;
            if (w_idx_clr) begin
                r_idx <= '0;
            end else if (w_idx_inc) begin
                r_idx <= r_idx + 1'b1;
            end
            if (w_acc_wr) begin
                r_acc[r_idx*Q_W +: Q_W] <= w_code;
            end
            if (w_save_hold) begin
                r_hold <= w_vec;
            end
            if (w_load_new) begin
                r_m_valid <= 1'b1;
                r_m_data  <= w_vec;
            end else if (w_load_hold) begin
                r_m_valid <= 1'b1;
                r_m_data  <= r_hold;
            end else if (m_ready) begin
                r_m_valid <= 1'b0;
            end
        end
    end

    assign m_valid = r_m_valid;
    assign m_data  = r_m_data;
    assign err_len = r_err;

endmodule
